// File: rtl/pluto_epp_pkg.sv
// Shared constants for the pluto EPP controller: FSM encoding, address width,
// snapshot source selects and a byte-lane helper.
package pluto_epp_pkg;

    localparam int ADDR_W = 5;

    localparam logic [1:0] ST_ARM  = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_ACT  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [2:0] SEL_QUAD0  = 3'd0;
    localparam logic [2:0] SEL_QUAD1  = 3'd1;
    localparam logic [2:0] SEL_QUAD2  = 3'd2;
    localparam logic [2:0] SEL_QUAD3  = 3'd3;
    localparam logic [2:0] SEL_INPUTS = 3'd4;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pluto_epp_if.sv
// Parallel-port EPP pin bundle; master is the host side, slave is the controller.
interface pluto_epp_if;
    logic       nWrite;
    logic       nAddrStr;
    logic       nDataStr;
    logic [7:0] pport_din;
    logic [7:0] pport_dout;
    logic       pport_oe;
    logic       nWait;

    modport master (output nWrite, nAddrStr, nDataStr, pport_din,
                    input  pport_dout, pport_oe, nWait);
    modport slave  (input  nWrite, nAddrStr, nDataStr, pport_din,
                    output pport_dout, pport_oe, nWait);
endinterface

// File: rtl/pluto_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; resets to 0.
module pluto_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pluto_epp_ctrl.sv
// EPP handshake controller: byte transfers into 16-bit register writes,
// 32-bit snapshot reads with address auto-increment, and a host-silence watchdog.
//
//  state | meaning
//  ARM   | after reset: wait for the synchronised strobe to be seen released
//  IDLE  | bus quiet, waiting for a strobe
//  ACT   | one cycle: sample the bus and perform the address/data action
//  HOLD  | nWait low until the host releases its strobe
module pluto_epp_ctrl
    import pluto_epp_pkg::*;
#(
    parameter int WD_TIMEOUT = 800000,
    parameter int WD_W       = 20
) (
    input  logic        clk,
    input  logic        reset,
    pluto_epp_if.slave  epp,
    output logic [3:0]  reg_addr,
    output logic        reg_wr,
    output logic [15:0] reg_wdata,
    output logic        reg_rd,
    output logic [2:0]  reg_rd_sel,
    input  logic [31:0] reg_rdata,
    output logic        wd_expired
);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_TIMEOUT);

    logic [1:0]        state;
    logic [1:0]        settle;
    logic              strb_s;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        lowbyte;
    logic [31:0]       rbuf;
    logic [7:0]        dout;
    logic              rd_cyc;
    logic [WD_W-1:0]   wd_cnt;
    logic              act;
    logic              addr_cyc;
    logic              data_cyc;
    logic [31:0]       rd_word;

    pluto_sync2 u_sync_strb (
        .clk   (clk),
        .reset (reset),
        .d     (~epp.nAddrStr | ~epp.nDataStr),
        .q     (strb_s)
    );

    assign act      = (state == ST_ACT);
    assign addr_cyc = ~epp.nAddrStr;
    assign data_cyc = ~epp.nDataStr & epp.nAddrStr;

    assign reg_wr     = act & data_cyc & ~epp.nWrite & addr[0];
    assign reg_rd     = act & data_cyc & epp.nWrite & (addr[1:0] == 2'b00);
    assign reg_addr   = addr[4:1];
    assign reg_wdata  = {epp.pport_din, lowbyte};
    assign reg_rd_sel = addr[4:2];
    assign rd_word    = reg_rd ? reg_rdata : rbuf;

    assign epp.nWait      = (state != ST_HOLD);
    assign epp.pport_oe   = (state == ST_HOLD) & rd_cyc;
    assign epp.pport_dout = dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_ARM;
            settle  <= 2'b00;
            addr    <= '0;
            lowbyte <= 8'h00;
            rbuf    <= 32'h0;
            dout    <= 8'h00;
            rd_cyc  <= 1'b0;
        end else begin
            // synchroniser comes out of reset at 0, so let it refill before trusting a low
            settle <= {settle[0], 1'b1};
            case (state)
                ST_ARM:  if (settle[1] && !strb_s) state <= ST_IDLE;
                ST_IDLE: if (strb_s) state <= ST_ACT;
                ST_ACT: begin
                    state  <= ST_HOLD;
                    rd_cyc <= epp.nWrite;
                    if (addr_cyc) begin
                        if (!epp.nWrite) addr <= epp.pport_din[ADDR_W-1:0];
                        else             dout <= {{(8-ADDR_W){1'b0}}, addr};
                    end else if (data_cyc) begin
                        if (!epp.nWrite) begin
                            if (!addr[0]) lowbyte <= epp.pport_din;
                        end else begin
                            if (reg_rd) rbuf <= reg_rdata;
                            dout <= byte_of(rd_word, addr[1:0]);
                        end
                        addr <= addr + 1'b1;
                    end
                end
                ST_HOLD: if (!strb_s) state <= ST_IDLE;
                default: state <= ST_ARM;
            endcase
        end
    end

    // expired is sticky from reset until the first register write
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt     <= '0;
            wd_expired <= 1'b1;
        end else if (reg_wr) begin
            wd_cnt     <= '0;
            wd_expired <= 1'b0;
        end else if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt + 1'b1 == WD_MAX) wd_expired <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pluto_epp_ctrl.sv
// Directed bench for pluto_epp_ctrl: EPP host transfers with hand-computed expectations.
module tb_pluto_epp_ctrl;
    import pluto_epp_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  reg_addr;
    logic        reg_wr;
    logic [15:0] reg_wdata;
    logic        reg_rd;
    logic [2:0]  reg_rd_sel;
    logic [31:0] reg_rdata;
    logic        wd_expired;

    pluto_epp_if epp();

    pluto_epp_ctrl #(.WD_TIMEOUT(16), .WD_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .epp        (epp),
        .reg_addr   (reg_addr),
        .reg_wr     (reg_wr),
        .reg_wdata  (reg_wdata),
        .reg_rd     (reg_rd),
        .reg_rd_sel (reg_rd_sel),
        .reg_rdata  (reg_rdata),
        .wd_expired (wd_expired)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cyc = 0;
    logic [3:0]  last_waddr = 4'h0;
    logic [15:0] last_wdata = 16'h0;
    logic [2:0]  last_sel = 3'h0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= reg_addr;
            last_wdata <= reg_wdata;
            wr_cyc     <= cyc;
        end
        if (reg_rd) begin
            rd_cnt   <= rd_cnt + 1;
            last_sel <= reg_rd_sel;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input bit is_addr, input bit rd, input logic [7:0] d, output logic [7:0] q);
        int lat;
        lat = 0;
        @(negedge clk);
        epp.nWrite    = rd;
        epp.pport_din = d;
        if (is_addr) epp.nAddrStr = 1'b0;
        else         epp.nDataStr = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (epp.nWait === 1'b0) begin
                lat = i;
                break;
            end
        end
        chk("latency", lat, 4);
        chk("oe_in_hold", epp.pport_oe, rd);
        q = epp.pport_dout;
        epp.nAddrStr = 1'b1;
        epp.nDataStr = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (epp.nWait === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("wait_release", lat != 0, 1);
        chk("oe_after_release", epp.pport_oe, 0);
    endtask

    initial begin
        logic [7:0] q;
        bit         saw_ack;

        // 1: strobe held low through reset must not act
        epp.nWrite    = 1'b0;
        epp.nAddrStr  = 1'b1;
        epp.nDataStr  = 1'b0;
        epp.pport_din = 8'h99;
        reg_rdata     = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_nwait", epp.nWait, 1);
        chk("rst_oe", epp.pport_oe, 0);
        chk("rst_wd_expired", wd_expired, 1);
        reset = 1'b0;
        saw_ack = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (epp.nWait !== 1'b1) saw_ack = 1'b1;
        end
        chk("arm_no_ack", saw_ack, 0);
        chk("arm_no_wr", wr_cnt, 0);
        chk("arm_no_rd", rd_cnt, 0);
        epp.nDataStr = 1'b1;
        repeat (4) @(negedge clk);

        // 2: byte pair into one register write, then address readback
        xfer(1, 0, 8'h00, q);
        xfer(0, 0, 8'h34, q);
        chk("low_byte_no_wr", wr_cnt, 0);
        xfer(0, 0, 8'h12, q);
        chk("pair_wr_cnt", wr_cnt, 1);
        chk("pair_waddr", last_waddr, 4'h0);
        chk("pair_wdata", last_wdata, 16'h1234);
        xfer(1, 1, 8'h00, q);
        chk("addr_read_2", q, 8'h02);
        xfer(1, 0, 8'h01, q);
        xfer(0, 0, 8'h56, q);
        chk("odd_wr_cnt", wr_cnt, 2);
        chk("odd_wdata", last_wdata, 16'h5634);
        xfer(1, 1, 8'h00, q);
        chk("addr_read_odd", q, 8'h02);

        // 3: coherent 32-bit snapshot read
        reg_rdata = 32'hA1B2C3D4;
        xfer(1, 0, 8'h04, q);
        xfer(0, 1, 8'h00, q);
        chk("rd_byte0", q, 8'hD4);
        chk("rd_cnt_1", rd_cnt, 1);
        chk("rd_sel", last_sel, 3'd1);
        reg_rdata = 32'hDEADBEEF;
        xfer(0, 1, 8'h00, q);
        chk("rd_byte1", q, 8'hC3);
        xfer(0, 1, 8'h00, q);
        chk("rd_byte2", q, 8'hB2);
        xfer(0, 1, 8'h00, q);
        chk("rd_byte3", q, 8'hA1);
        chk("rd_cnt_single", rd_cnt, 1);
        xfer(1, 1, 8'h00, q);
        chk("addr_after_rd", q, 8'h08);

        // 4: address wrap 31 -> 0
        xfer(1, 0, 8'h1E, q);
        xfer(0, 0, 8'h55, q);
        chk("wrap_low_no_wr", wr_cnt, 2);
        xfer(0, 0, 8'hAA, q);
        chk("wrap_wr_cnt", wr_cnt, 3);
        chk("wrap_waddr", last_waddr, 4'hF);
        chk("wrap_wdata", last_wdata, 16'hAA55);
        xfer(1, 1, 8'h00, q);
        chk("wrap_addr", q, 8'h00);
        xfer(0, 0, 8'h11, q);
        xfer(0, 0, 8'h22, q);
        chk("post_wrap_waddr", last_waddr, 4'h0);
        chk("post_wrap_wdata", last_wdata, 16'h2211);

        // 6: reset during HOLD of a read; lowbyte 0x11 is pending
        xfer(1, 0, 8'h04, q);
        @(negedge clk);
        epp.nWrite   = 1'b1;
        epp.nDataStr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (epp.nWait === 1'b0) break;
        end
        chk("pre_rst_oe", epp.pport_oe, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_nwait", epp.nWait, 1);
        chk("midrst_oe", epp.pport_oe, 0);
        chk("midrst_state", dut.state, ST_ARM);
        reset = 1'b0;
        saw_ack = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (epp.nWait !== 1'b1) saw_ack = 1'b1;
        end
        chk("midrst_arm_hold", saw_ack, 0);
        chk("midrst_rd_cnt", rd_cnt, 2);
        epp.nDataStr = 1'b1;
        repeat (4) @(negedge clk);
        xfer(1, 1, 8'h00, q);
        chk("midrst_addr", q, 8'h00);
        xfer(1, 0, 8'h01, q);
        xfer(0, 0, 8'h88, q);
        chk("lowbyte_discard", last_wdata, 16'h8800);

        // 5: watchdog, timeout 16
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("wd_after_rst", wd_expired, 1);
        repeat (20) @(negedge clk);
        chk("wd_no_writes", wd_expired, 1);
        xfer(1, 0, 8'h00, q);
        xfer(0, 0, 8'h01, q);
        xfer(0, 0, 8'h02, q);
        chk("wd_wr_cnt", wr_cnt, 6);
        chk("wd_cleared", wd_expired, 0);
        for (int i = 0; i < 40; i++) begin
            if (cyc >= wr_cyc + 16) break;
            @(negedge clk);
        end
        chk("wd_cycle_reached", cyc, wr_cyc + 16);
        chk("wd_not_yet", wd_expired, 0);
        @(negedge clk);
        chk("wd_reasserted", wd_expired, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
